wishbone_sram_responder: RTL

WISHBONE_SRAM_RESPONDER -- requirements
Module: wishbone_sram_responder

---
 rtl/wishbone_sram_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wishbone_sram_responder.sv
// Wishbone word-addressed SRAM responder with programmable wait states, 1/4/8-word bursts,
// byte-enabled writes and a whole-span range check that answers out-of-range requests with err.
`ifndef RW
`define RW 16
`endif
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module wishbone_sram_responder #(
    parameter logic [`WB_ADDR_W-1:0] BASE_ADR    = 24'h000000,
    parameter int                    DEPTH_LOG2  = 8,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic [`WB_ADDR_W-1:0] wb_adr,
    input  logic [`RW-1:0]        wb_i_dat,
    input  logic                  wb_we,
    input  logic [1:0]            wb_sel,
    input  logic                  wb_8_burst,
    input  logic                  wb_4_burst,
    output logic [`RW-1:0]        wb_o_dat,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic [1:0]            o_dbg_state
);

    localparam int AW    = `WB_ADDR_W;
    localparam int DW    = `RW;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [AW:0]           LP_WORDS     = {{AW{1'b0}}, 1'b1} << DEPTH_LOG2;
    localparam logic [3:0]            LP_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [DEPTH_LOG2-1:0] LP_IDX_ONE   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DW-1:0]         r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_we;
    logic                  r_bad;
    logic [3:0]            r_len;
    logic [3:0]            r_cnt;
    logic [3:0]            r_wait;
    logic [DW-1:0]         r_dat;
    logic                  r_ack;
    logic                  r_err;

    logic [3:0]            w_len;
    logic [AW-1:0]         w_off;
    logic [AW:0]           w_span;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_next_we;
    logic [DEPTH_LOG2-1:0] w_acc_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic                  w_wr_en;

    // The whole burst must fit: offset must not underflow and offset+N must not pass the top word.
    always_comb begin
        w_len = 4'd1;
        if (wb_8_burst)      w_len = 4'd8;
        else if (wb_4_burst) w_len = 4'd4;
    end

    assign w_off      = wb_adr - BASE_ADR;
    assign w_span     = {1'b0, w_off} + {{(AW-3){1'b0}}, w_len};
    assign w_in_range = (wb_adr >= BASE_ADR) && (w_span <= LP_WORDS);
    assign w_acc_idx  = w_off[DEPTH_LOG2-1:0];

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES > 0) w_next = WAIT;
                    else                 w_next = w_in_range ? XFER : ERR;
                end
            end
            WAIT: begin
                if (!wb_cyc)           w_next = IDLE;
                else if (r_wait == 4'd0) w_next = r_bad ? ERR : XFER;
            end
            XFER: begin
                if (!wb_cyc || (r_cnt == r_len - 4'd1)) w_next = IDLE;
            end
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (!i_rst) begin
            w_next   = IDLE;
            w_accept = 1'b0;
        end
    end

    // Read data is registered, so fetch the word that the upcoming ack cycle will present.
    assign w_next_we = w_accept ? wb_we : r_we;
    assign w_rd_idx  = w_accept ? w_acc_idx :
                       (r_state == XFER) ? (r_idx + LP_IDX_ONE) : r_idx;
    assign w_wr_en   = i_rst && wb_cyc && (r_state == XFER) && r_we;

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_dat  <= '0;
            r_cnt  <= 4'd0;
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_bad  <= 1'b0;
            r_len  <= 4'd1;
            r_wait <= 4'd0;
        end else begin
            r_ack <= (w_next == XFER);
            r_err <= (w_next == ERR);
            if (w_accept) begin
                r_idx  <= w_acc_idx;
                r_we   <= wb_we;
                r_len  <= w_len;
                r_bad  <= !w_in_range;
                r_wait <= LP_WAIT_INIT;
                r_cnt  <= 4'd0;
            end else if (r_state == XFER) begin
                r_idx <= r_idx + LP_IDX_ONE;
                r_cnt <= r_cnt + 4'd1;
            end else if (r_state == WAIT) begin
                r_wait <= r_wait - 4'd1;
            end
            if ((w_next == XFER) && !w_next_we) r_dat <= r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            if (wb_sel[0]) r_mem[r_idx][7:0]  <= wb_i_dat[7:0];
            if (wb_sel[1]) r_mem[r_idx][15:8] <= wb_i_dat[15:8];
        end
    end

    assign wb_o_dat    = r_dat;
    assign wb_ack      = r_ack;
    assign wb_err      = r_err;
    assign o_dbg_state = r_state;

endmodule
